// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4
//   Shares one downstream resource between four requesters. The highest
//   set request index wins. The grant is registered, one-hot, and carries a
//   binary owner ID. The owner keeps the grant until one of these happens:
//   it drops req, it pulses done, or the hold counter reaches MAX_HOLD.
//   Every release is followed by one dead GAP cycle, so the resource always
//   sees a break before the next grant is made.
//
//   Optional feature: define ARB_ROUND_ROBIN_EN to replace fixed priority
//   with rotating priority. The search then starts just above the last owner.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   level request per client
//   done[3:0]  single-cycle release pulse; only the owner's bit is honoured
//   gnt[3:0]   registered one-hot grant, zero when idle
//   gnt_id     binary owner index, zero when no grant is active
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse when MAX_HOLD force-releases the owner
module priority_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       gnt_r, gnt_s;
  logic [1:0]       id_r, id_s;
  logic             valid_r, valid_s;
  logic             timeout_r, timeout_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       winner_s;
  logic             own_req_s;
  logic             own_done_s;
  logic             at_max_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_r, last_s;

  // Rotating search from last+1 upward with wrap-around. The loop walks the
  // order backwards, so the last match it writes is the first index in order.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    res = 2'b00;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection under rotating priority
  always_comb begin
    winner_s = rr_pick(req, last_r);
  end
`else
  // Winner selection under fixed priority, bit 3 highest
  always_comb begin
    winner_s = 2'b00;
    casez (req)
      4'b1???: winner_s = 2'b11;
      4'b01??: winner_s = 2'b10;
      4'b001?: winner_s = 2'b01;
      default: winner_s = 2'b00;
    endcase
  end
`endif

  // Owner status terms used by the release decision
  always_comb begin
    own_req_s  = req[id_r];
    own_done_s = done[id_r];
    at_max_s   = (cnt_r == CNT_W'(MAX_HOLD));
  end

  // Next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    id_s      = id_r;
    valid_s   = valid_r;
    timeout_s = 1'b0;
    cnt_s     = cnt_r;
`ifdef ARB_ROUND_ROBIN_EN
    last_s    = last_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (req != 4'b0000) begin
          gnt_s   = 4'b0001 << winner_s;
          id_s    = winner_s;
          valid_s = 1'b1;
          cnt_s   = CNT_W'(1);
          state_s = GRANT;
`ifdef ARB_ROUND_ROBIN_EN
          last_s  = winner_s;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!own_req_s || own_done_s || at_max_s) begin
          gnt_s     = 4'b0000;
          id_s      = 2'b00;
          valid_s   = 1'b0;
          // The release counts as a timeout only when MAX_HOLD alone caused it.
          timeout_s = at_max_s && own_req_s && !own_done_s;
          state_s   = GAP;
        end else begin
          if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end
      end
      GAP: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = IDLE;
      end
      default: begin
        gnt_s   = 4'b0000;
        id_s    = 2'b00;
        valid_s = 1'b0;
        cnt_s   = {CNT_W{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt_r     <= 4'b0000;
      id_r      <= 2'b00;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_r    <= 2'b11;
`endif
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      id_r      <= id_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
      cnt_r     <= cnt_s;
`ifdef ARB_ROUND_ROBIN_EN
      last_r    <= last_s;
`endif
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = id_r;
  assign gnt_valid = valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_priority_arbiter_4.sv
module tb_priority_arbiter_4;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner (-1 means none), cycles held, cooldown edges
  // before arbitration may run again, and the last owner for rotation.
  int m_owner;
  int m_held;
  int m_cool;
  int m_last;
  bit m_timeout;

  priority_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 1; i <= 4; i++) begin
      if (r[(m_last + i) % 4]) return (m_last + i) % 4;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_cool    = 0;
    m_last    = 3;
    m_timeout = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_timeout = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner] || done[m_owner] || m_held >= MAX_HOLD) begin
          m_timeout = (m_held >= MAX_HOLD) && req[m_owner] && !done[m_owner];
          m_owner   = -1;
          m_cool    = 1;
        end else begin
          m_held++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (req != 4'b0000) begin
        m_owner = pick(req);
        m_held  = 1;
        m_last  = m_owner;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("timeout", 32'(timeout), 32'(m_timeout));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic go_idle();
    req  = 4'b0000;
    done = 4'b0000;
    repeat (4) step();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!gnt_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(gnt_valid), 32'd1);
  endtask

  int seq_got[5];
  int seq_exp[5];
  int nvalid;
  int tos;

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    model_reset();
    #2;
    compare_all();
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();

    // Priority: 0110 -> owner 2, then owner 1 after release
    req = 4'b0110;
    step();
    check("prio_gnt", 32'(gnt), 32'h4);
    check("prio_id", 32'(gnt_id), 32'h2);
    req = 4'b0010;
    step();
    check("gap_gnt", 32'(gnt), 32'h0);
    step();
    step();
    check("next_gnt", 32'(gnt), 32'h2);
    check("next_id", 32'(gnt_id), 32'h1);
    go_idle();

    // No preemption, then done release
    req = 4'b0001;
    step();
    req = 4'b1001;
    repeat (3) step();
    check("nopreempt", 32'(gnt), 32'h1);
    done = 4'b1000;
    step();
    check("nonowner_done", 32'(gnt), 32'h1);
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    step();
    check("handover", 32'(gnt), 32'h8);
    go_idle();

    // Timeout with req held
    req = 4'b0001;
    wait_valid("to_start");
    nvalid = 1;
    tos = 0;
    while (gnt_valid && nvalid < 40) begin
      step();
      if (gnt_valid) nvalid++;
      if (timeout) tos++;
    end
    check("hold_len", 32'(nvalid), 32'd16);
    check("timeout_pulse", 32'(timeout), 32'd1);
    step();
    check("timeout_single", 32'(timeout), 32'd0);
    step();
    check("regrant", 32'(gnt), 32'h1);
    check("timeout_count", 32'(tos), 32'd1);
    go_idle();

    // done on the 16th cycle: normal release, no timeout
    req = 4'b0001;
    wait_valid("done16_start");
    repeat (15) step();
    done = 4'b0001;
    step();
    done = 4'b0000;
    check("done16_rel", 32'(gnt_valid), 32'd0);
    check("done16_to", 32'(timeout), 32'd0);
    go_idle();

    // Async reset mid-grant
    req = 4'b0100;
    step();
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_valid", 32'(gnt_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h4);
    go_idle();

    // Grant sequence with all requesting, done two cycles into each grant
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp = '{0, 1, 2, 3, 0};
`else
    seq_exp = '{3, 3, 3, 3, 3};
`endif
    for (int g = 0; g < 5; g++) begin
      wait_valid("seq_wait");
      seq_got[g] = int'(gnt_id);
      step();
      done = 4'b0001 << gnt_id;
      step();
      done = 4'b0000;
    end
    for (int g = 0; g < 5; g++) begin
      check("seq_owner", 32'(seq_got[g]), 32'(seq_exp[g]));
    end
    go_idle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst  = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
